// File: rtl/servo_sched_pkg.sv
// Shared flight-control definitions: scheduler state encodings and datapath widths.
package servo_sched_pkg;

    localparam int FRAME_CNT_W = 16;
    localparam int CMD_W       = 10;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

endpackage

// File: rtl/servo_slew.sv
// One channel of slew limiting: step current toward target by at most i_step,
// never overshooting. Arithmetic is one bit wider than the command.
module servo_slew
    import servo_sched_pkg::*;
(
    input  logic [CMD_W-1:0] i_current,
    input  logic [CMD_W-1:0] i_target,
    input  logic [CMD_W-1:0] i_step,
    output logic [CMD_W-1:0] o_next
);

    logic [CMD_W:0] w_up;
    logic [CMD_W:0] w_dn;
    logic [CMD_W:0] w_tgt;

    assign w_tgt = {1'b0, i_target};
    assign w_up  = {1'b0, i_current} + {1'b0, i_step};
    assign w_dn  = {1'b0, i_current} - {1'b0, i_step};

    // w_dn[CMD_W] set means current - step went below zero
    always_comb begin
        o_next = i_current;
        if (i_target > i_current) begin
            if (w_up > w_tgt) o_next = i_target;
            else              o_next = w_up[CMD_W-1:0];
        end else if (i_target < i_current) begin
            if (w_dn[CMD_W] || (w_dn < w_tgt)) o_next = i_target;
            else                               o_next = w_dn[CMD_W-1:0];
        end
    end

endmodule

// File: rtl/servo_sched.sv
// Servo command scheduler: arms on a held request, slews per-channel commands once
// per frame, and falls back to a fixed failsafe command when writes stop arriving.
module servo_sched
    import servo_sched_pkg::*;
#(
    parameter int               NCH            = 4,
    parameter logic [CMD_W-1:0] SLEW_STEP      = 10'd16,
    parameter int               ARM_FRAMES     = 4,
    parameter int               TIMEOUT_FRAMES = 8,
    parameter logic [CMD_W-1:0] FAILSAFE_CMD   = 10'd0,
    parameter int               FRAME_W        = FRAME_CNT_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr,
    input  logic [1:0]           i_wr_ch,
    input  logic [CMD_W-1:0]     i_wr_data,
    input  logic                 i_arm,
    output logic [NCH*CMD_W-1:0] o_cmd,
    output logic                 o_frame,
    output logic [1:0]           o_state,
    output logic                 o_failsafe
);

    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [AW-1:0]      ARM_LAST  = AW'(ARM_FRAMES - 1);
    localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_PRE = {{(FRAME_W-1){1'b1}}, 1'b0};

    state_t                      r_state;
    logic [AW-1:0]               r_arm_cnt;
    logic [TW-1:0]               r_tmo_cnt;
    logic                        r_failsafe;
    logic                        r_frame;
    logic [FRAME_W-1:0]          r_frame_cnt;
    logic [NCH-1:0][CMD_W-1:0]   r_cmd;
    logic [NCH-1:0][CMD_W-1:0]   r_target;
    logic [CMD_W-1:0]            w_slew     [NCH];
    logic [CMD_W-1:0]            w_slew_cur [NCH];
    logic                        w_wr_valid;

    assign w_wr_valid = i_wr && (int'(i_wr_ch) < NCH);

    assign o_cmd      = r_cmd;
    assign o_frame    = r_frame;
    assign o_state    = r_state;
    assign o_failsafe = r_failsafe;

    // r_frame is high exactly while the counter holds all-ones
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_cnt <= '0;
            r_frame     <= 1'b0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_frame     <= (r_frame_cnt == FRAME_PRE);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_target <= '0;
        end else if (w_wr_valid) begin
            r_target[i_wr_ch] <= i_wr_data;
        end
    end

    // Slew starts from zero on the frame that enters ARMED
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_slew_cur[g] = (r_state == ST_ARMED) ? r_cmd[g] : '0;
        servo_slew u_slew (
            .i_current (w_slew_cur[g]),
            .i_target  (r_target[g]),
            .i_step    (SLEW_STEP),
            .o_next    (w_slew[g])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_DISARMED;
            r_arm_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_failsafe <= 1'b0;
            r_cmd      <= '0;
        end else begin
            if (w_wr_valid) r_tmo_cnt <= '0;
            if (r_frame) begin
                case (r_state)
                    ST_DISARMED: begin
                        r_cmd <= '0;
                        if (i_arm) begin
                            r_state   <= ST_ARMING;
                            r_arm_cnt <= AW'(1);
                        end
                    end
                    ST_ARMING: begin
                        if (!i_arm) begin
                            r_state   <= ST_DISARMED;
                            r_arm_cnt <= '0;
                            r_cmd     <= '0;
                        end else if (r_arm_cnt == ARM_LAST) begin
                            r_state   <= ST_ARMED;
                            r_arm_cnt <= '0;
                            r_tmo_cnt <= '0;
                            for (int i = 0; i < NCH; i++) r_cmd[i] <= w_slew[i];
                        end else begin
                            r_arm_cnt <= r_arm_cnt + 1'b1;
                            r_cmd     <= '0;
                        end
                    end
                    ST_ARMED: begin
                        // Disarm wins over a timeout landing on the same frame
                        if (!i_arm) begin
                            r_state <= ST_DISARMED;
                            r_cmd   <= '0;
                        end else if (!w_wr_valid && (r_tmo_cnt >= TMO_LAST)) begin
                            r_state    <= ST_FAILSAFE;
                            r_failsafe <= 1'b1;
                            r_tmo_cnt  <= TW'(TIMEOUT_FRAMES);
                            r_cmd      <= {NCH{FAILSAFE_CMD}};
                        end else begin
                            for (int i = 0; i < NCH; i++) r_cmd[i] <= w_slew[i];
                            if (!w_wr_valid) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                    ST_FAILSAFE: begin
                        if (!i_arm) begin
                            r_state    <= ST_DISARMED;
                            r_failsafe <= 1'b0;
                            r_cmd      <= '0;
                        end else begin
                            r_cmd <= {NCH{FAILSAFE_CMD}};
                        end
                    end
                    default: r_state <= ST_DISARMED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_sched.sv
// Bench for servo_sched: directed scenarios plus randomized traffic, all checked
// against a frame-level behavioural model of the scheduler.
module tb_servo_sched;

    localparam int NCH        = 3;
    localparam int FW         = 4;
    localparam int FPER       = 16;
    localparam int ARM_FRAMES = 4;
    localparam int TIMEOUT    = 8;
    localparam int STEP       = 16;
    localparam int FS_CMD     = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr = 1'b0;
    logic [1:0]        wr_ch = '0;
    logic [9:0]        wr_data = '0;
    logic              arm = 1'b0;
    logic [NCH*10-1:0] cmd;
    logic              frame;
    logic [1:0]        state;
    logic              failsafe;

    servo_sched #(
        .NCH            (NCH),
        .SLEW_STEP      (10'(STEP)),
        .ARM_FRAMES     (ARM_FRAMES),
        .TIMEOUT_FRAMES (TIMEOUT),
        .FAILSAFE_CMD   (10'(FS_CMD)),
        .FRAME_W        (FW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr       (wr),
        .i_wr_ch    (wr_ch),
        .i_wr_data  (wr_data),
        .i_arm      (arm),
        .o_cmd      (cmd),
        .o_frame    (frame),
        .o_state    (state),
        .o_failsafe (failsafe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model: counter position, state number, consecutive-arm count,
    // frames since last activity, targets and commands as plain integers.
    int m_cnt = 0;
    int m_state = 0;
    int m_run = 0;
    int m_idle = 0;
    int m_cmd [NCH] = '{default: 0};
    int m_tgt [NCH] = '{default: 0};
    bit m_fed = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int ns, cur, tgt;
        bit w;
        if (rst) begin
            m_cnt = 0; m_state = 0; m_run = 0; m_idle = 0; m_fed = 1'b0;
            for (int c = 0; c < NCH; c++) begin m_cmd[c] = 0; m_tgt[c] = 0; end
        end else begin
            w = wr && (int'(wr_ch) < NCH);
            m_fed = (m_cnt == FPER - 1);
            if (m_fed) begin
                m_run = arm ? m_run + 1 : 0;
                ns = m_state;
                case (m_state)
                    0: if (arm) ns = 1;
                    1: if (!arm) ns = 0; else if (m_run >= ARM_FRAMES) ns = 2;
                    2: if (!arm) ns = 0; else if (!w && m_idle + 1 >= TIMEOUT) ns = 3;
                    default: if (!arm) ns = 0;
                endcase
                for (int c = 0; c < NCH; c++) begin
                    if (ns == 2) begin
                        cur = (m_state == 2) ? m_cmd[c] : 0;
                        tgt = m_tgt[c];
                        if (tgt > cur)      m_cmd[c] = (cur + STEP < tgt) ? cur + STEP : tgt;
                        else if (tgt < cur) m_cmd[c] = (cur - STEP > tgt) ? cur - STEP : tgt;
                        else                m_cmd[c] = cur;
                    end else if (ns == 3) m_cmd[c] = FS_CMD;
                    else m_cmd[c] = 0;
                end
                if (ns == 2 && m_state != 2) m_idle = 0;
                else if (m_state == 2 && !w) m_idle = (m_idle + 1 > TIMEOUT) ? TIMEOUT : m_idle + 1;
                m_state = ns;
            end
            if (w) begin
                m_tgt[wr_ch] = int'(wr_data);
                m_idle = 0;
            end
            m_cnt = (m_cnt + 1) % FPER;
        end
    end

    function automatic logic [NCH*10-1:0] model_cmd();
        logic [NCH*10-1:0] v;
        for (int c = 0; c < NCH; c++) v[10*c +: 10] = 10'(m_cmd[c]);
        return v;
    endfunction

    function automatic logic [NCH*10-1:0] model_tgt();
        logic [NCH*10-1:0] v;
        for (int c = 0; c < NCH; c++) v[10*c +: 10] = 10'(m_tgt[c]);
        return v;
    endfunction

    // Returns at the falling edge just after the next frame edge
    task automatic next_frame();
        int guard = 0;
        do begin @(negedge clk); guard++; end while (!m_fed && guard < 3 * FPER);
        if (!m_fed) begin
            n_vec++; n_err++;
            $display("FAIL frame_wait: no frame edge within %0d cycles", guard);
        end
    endtask

    task automatic do_write(input int ch, input int data);
        while (m_cnt == FPER - 1) @(negedge clk);
        wr = 1'b1; wr_ch = 2'(ch); wr_data = 10'(data);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic write_at_frame(input int ch, input int data);
        int guard = 0;
        while (m_cnt != FPER - 1 && guard < 2 * FPER) begin @(negedge clk); guard++; end
        wr = 1'b1; wr_ch = 2'(ch); wr_data = 10'(data);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic arm_up();
        arm = 1'b0;
        next_frame();
        arm = 1'b1;
        repeat (ARM_FRAMES) next_frame();
        n_vec++;
        if (state !== 2'd2) begin n_err++; $display("FAIL arm_up_state: got %0d want 2", state); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (cmd !== '0) begin n_err++; $display("FAIL reset_cmd: got %h want 0", cmd); end
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_vec++; if (failsafe !== 1'b0) begin n_err++; $display("FAIL reset_failsafe: got %b want 0", failsafe); end
        n_vec++; if (frame !== 1'b0) begin n_err++; $display("FAIL reset_frame: got %b want 0", frame); end
        n_vec++; if (dut.r_frame_cnt !== '0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", dut.r_frame_cnt); end
    endtask

    task automatic test_arm();
        int exp_s, exp_c;
        rst = 1'b0;
        arm = 1'b1;
        do_write(0, 512);
        for (int k = 1; k <= 36; k++) begin
            next_frame();
            exp_s = (k < ARM_FRAMES) ? 1 : 2;
            exp_c = (k < ARM_FRAMES) ? 0 : ((STEP * (k - ARM_FRAMES + 1) < 512) ? STEP * (k - ARM_FRAMES + 1) : 512);
            n_vec++;
            if (state !== 2'(exp_s)) begin n_err++; $display("FAIL arm_state f%0d: got %0d want %0d", k, state, exp_s); end
            n_vec++;
            if (int'(cmd[9:0]) != exp_c) begin n_err++; $display("FAIL arm_cmd0 f%0d: got %0d want %0d", k, cmd[9:0], exp_c); end
            n_vec++;
            if (cmd !== model_cmd()) begin n_err++; $display("FAIL arm_model f%0d: got %h want %h", k, cmd, model_cmd()); end
            do_write(0, 512);
        end
    endtask

    task automatic test_slew_down();
        do_write(0, 500);
        next_frame();
        n_vec++; if (cmd[9:0] !== 10'd500) begin n_err++; $display("FAIL slew_down_cmd0: got %0d want 500", cmd[9:0]); end
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL slew_down_state: got %0d want 2", state); end
    endtask

    task automatic test_arm_abort();
        arm = 1'b0;
        next_frame();
        arm = 1'b1;
        next_frame();
        next_frame();
        n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL abort_arming: got %0d want 1", state); end
        arm = 1'b0;
        next_frame();
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL abort_disarm: got %0d want 0", state); end
        n_vec++; if (cmd !== '0) begin n_err++; $display("FAIL abort_cmd: got %h want 0", cmd); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            arm = ($urandom_range(0, 7) != 0);
            for (int j = $urandom_range(0, 2); j > 0; j--)
                do_write($urandom_range(0, 3), $urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) write_at_frame($urandom_range(0, 3), $urandom_range(0, 1023));
            else next_frame();
            n_vec++;
            if (state !== 2'(m_state)) begin n_err++; $display("FAIL rand_state f%0d: got %0d want %0d", k, state, m_state); end
            n_vec++;
            if (failsafe !== (m_state == 3)) begin n_err++; $display("FAIL rand_failsafe f%0d: got %b want %b", k, failsafe, m_state == 3); end
            n_vec++;
            if (cmd !== model_cmd()) begin n_err++; $display("FAIL rand_cmd f%0d: got %h want %h", k, cmd, model_cmd()); end
        end
    endtask

    task automatic test_boundary_and_timeout();
        arm_up();
        for (int k = 0; k < 9; k++) begin do_write(1, 100); next_frame(); end
        n_vec++; if (cmd[19:10] !== 10'd100) begin n_err++; $display("FAIL bnd_settle_cmd1: got %0d want 100", cmd[19:10]); end
        write_at_frame(1, 200);
        n_vec++; if (cmd[19:10] !== 10'd100) begin n_err++; $display("FAIL bnd_old_target: got %0d want 100", cmd[19:10]); end
        n_vec++; if (dut.r_tmo_cnt !== '0) begin n_err++; $display("FAIL bnd_timeout_cnt: got %0d want 0", dut.r_tmo_cnt); end
        // No further writes: the coincident write was the last activity
        for (int k = 1; k <= TIMEOUT; k++) begin
            next_frame();
            if (k == 1) begin
                n_vec++;
                if (cmd[19:10] !== 10'd116) begin n_err++; $display("FAIL bnd_new_target: got %0d want 116", cmd[19:10]); end
            end
            n_vec++;
            if (state !== ((k < TIMEOUT) ? 2'd2 : 2'd3)) begin n_err++; $display("FAIL tmo_state f%0d: got %0d want %0d", k, state, (k < TIMEOUT) ? 2 : 3); end
            n_vec++;
            if (failsafe !== (k == TIMEOUT)) begin n_err++; $display("FAIL tmo_failsafe f%0d: got %b want %b", k, failsafe, k == TIMEOUT); end
            n_vec++;
            if (cmd !== model_cmd()) begin n_err++; $display("FAIL tmo_model f%0d: got %h want %h", k, cmd, model_cmd()); end
        end
        n_vec++; if (cmd !== {NCH{10'(FS_CMD)}}) begin n_err++; $display("FAIL tmo_fs_cmd: got %h want %h", cmd, {NCH{10'(FS_CMD)}}); end
        do_write(0, 300);
        next_frame();
        n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL fs_sticky: got %0d want 3", state); end
        arm = 1'b0;
        next_frame();
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL fs_exit_state: got %0d want 0", state); end
        n_vec++; if (failsafe !== 1'b0) begin n_err++; $display("FAIL fs_exit_flag: got %b want 0", failsafe); end
        n_vec++; if (cmd !== '0) begin n_err++; $display("FAIL fs_exit_cmd: got %h want 0", cmd); end
    endtask

    task automatic test_invalid_ch();
        arm_up();
        for (int k = 1; k <= TIMEOUT; k++) begin
            do_write(3, $urandom_range(0, 1023));
            next_frame();
            n_vec++;
            if (state !== ((k < TIMEOUT) ? 2'd2 : 2'd3)) begin n_err++; $display("FAIL inv_state f%0d: got %0d want %0d", k, state, (k < TIMEOUT) ? 2 : 3); end
            n_vec++;
            if (cmd !== model_cmd()) begin n_err++; $display("FAIL inv_cmd f%0d: got %h want %h", k, cmd, model_cmd()); end
        end
        n_vec++; if (dut.r_target !== model_tgt()) begin n_err++; $display("FAIL inv_targets: got %h want %h", dut.r_target, model_tgt()); end
    endtask

    task automatic test_midframe_reset();
        int n;
        arm_up();
        for (int k = 0; k < 22; k++) begin do_write(0, 300); next_frame(); end
        n_vec++; if (cmd[9:0] !== 10'd300) begin n_err++; $display("FAIL mrst_pre_cmd0: got %0d want 300", cmd[9:0]); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (cmd !== '0) begin n_err++; $display("FAIL mrst_cmd: got %h want 0", cmd); end
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL mrst_state: got %0d want 0", state); end
        n_vec++; if (dut.r_frame_cnt !== '0) begin n_err++; $display("FAIL mrst_frame_cnt: got %0d want 0", dut.r_frame_cnt); end
        n_vec++; if (frame !== 1'b0) begin n_err++; $display("FAIL mrst_frame: got %b want 0", frame); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        arm = 1'b0;
        // Counter reaches all-ones after 2**FW-1 edges; the frame edge is the 2**FW-th
        n = 0;
        do begin @(negedge clk); n++; end while (frame !== 1'b1 && n < 3 * FPER);
        n_vec++; if (n + 1 != FPER) begin n_err++; $display("FAIL mrst_first_frame: got edge %0d want %0d", n + 1, FPER); end
        @(negedge clk);
        n_vec++; if (frame !== 1'b0) begin n_err++; $display("FAIL mrst_frame_width: got %b want 0", frame); end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_slew_down();
        test_arm_abort();
        test_random();
        test_boundary_and_timeout();
        test_invalid_ch();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
